// File: rtl/pc_display_pkg.sv
// Shared types and seven-segment helpers for pc_step_display.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package pc_display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] val);
    if (val < 4'd10) return SEG_DIGIT[val];
    return SEG_OFF;
  endfunction

  // Decimal digits needed to show the largest value of a bits-wide field.
  function automatic int min_digits(input int bits);
    longint unsigned max_v;
    int n;
    max_v = (64'd1 << bits) - 64'd1;
    n = 1;
    while (max_v >= 64'd10) begin
      max_v = max_v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_step_display_key_debouncer.sv
// Debouncer for the synchronised active-low step key; emits one press_pulse
// after a high->low change has held for DEBOUNCE_CYC cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_sync,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= RELOAD;
      level       <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (key_n_sync == level) begin
        cnt <= RELOAD;
      end else if (cnt == '0) begin
        level       <= key_n_sync;
        press_pulse <= ~key_n_sync;
        cnt         <= RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_step_display.sv
// PC stepper with sequential double-dabble decimal readout on HEX displays.
// Optional free-running step tick is built when PC_AUTORUN_EN is defined.
//   state | meaning
//   IDLE  | display up to date, waiting for the field to change
//   SHIFT | double-dabble shifting, one field bit per cycle
//   DONE  | publish segments, restart if the field moved meanwhile
module pc_step_display
  import pc_display_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int PC_STEP      = 4,
  parameter int DISP_LSB     = 2,
  parameter int DISP_BITS    = 8,
  parameter int DIGITS       = 3,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RUN_DIV      = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_key_n,
  input  logic                  run_en,
  input  logic                  load,
  input  logic [PC_WIDTH-1:0]   load_value,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [7*DIGITS-1:0]   hex_n,
  output logic                  disp_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DISP_BITS + 1);

  if (DIGITS < min_digits(DISP_BITS)) begin : g_bad_digits
    $error("DIGITS too small to show DISP_BITS-wide field");
  end
  if (DISP_LSB + DISP_BITS > PC_WIDTH) begin : g_bad_field
    $error("display field exceeds PC_WIDTH");
  end

  logic [1:0] key_sync;
  logic       step_evt;
  logic       run_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) key_sync <= 2'b11;
    else       key_sync <= {key_sync[0], step_key_n};
  end

  key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk         (clk),
    .reset       (reset),
    .key_n_sync  (key_sync[1]),
    .press_pulse (step_evt)
  );

`ifdef PC_AUTORUN_EN
  localparam int RUN_W = $clog2(RUN_DIV + 1);
  logic [RUN_W-1:0] run_cnt;

  // Held at reload while disabled so the first tick is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 run_cnt <= RUN_W'(RUN_DIV - 1);
    else if (!run_en)          run_cnt <= RUN_W'(RUN_DIV - 1);
    else if (run_cnt == '0)    run_cnt <= RUN_W'(RUN_DIV - 1);
    else                       run_cnt <= run_cnt - 1'b1;
  end
  assign run_tick = run_en && (run_cnt == '0);
`else
  localparam int unused_run_div = RUN_DIV;
  logic unused_run_en;
  assign unused_run_en = run_en;
  assign run_tick      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    pc <= '0;
    else if (load)                pc <= load_value;
    else if (step_evt || run_tick) pc <= pc + PC_WIDTH'(PC_STEP);
  end

  logic [DISP_BITS-1:0] f;
  assign f = pc[DISP_LSB +: DISP_BITS];

  bcd_state_t           state, state_nxt;
  logic [DISP_BITS-1:0] conv_f, conv_f_nxt, shown_f, shown_f_nxt, bin_sh, bin_nxt;
  logic [BCD_W-1:0]     bcd, bcd_nxt, bcd_adj;
  logic [CNT_W-1:0]     bit_cnt, cnt_nxt;
  logic                 pending, pend_nxt;
  logic [7*DIGITS-1:0]  hex_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      conv_f  <= '0;
      shown_f <= '0;
      bin_sh  <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      hex_n   <= {DIGITS{SEG_DIGIT[0]}};
    end else begin
      state   <= state_nxt;
      conv_f  <= conv_f_nxt;
      shown_f <= shown_f_nxt;
      bin_sh  <= bin_nxt;
      bcd     <= bcd_nxt;
      bit_cnt <= cnt_nxt;
      pending <= pend_nxt;
      hex_n   <= hex_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    conv_f_nxt  = conv_f;
    shown_f_nxt = shown_f;
    bin_nxt     = bin_sh;
    bcd_nxt     = bcd;
    cnt_nxt     = bit_cnt;
    pend_nxt    = pending;
    hex_nxt     = hex_n;
    bcd_adj     = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (f != conv_f) begin
          conv_f_nxt = f;
          bin_nxt    = f;
          bcd_nxt    = '0;
          cnt_nxt    = CNT_W'(DISP_BITS - 1);
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_nxt = {bcd_adj[BCD_W-2:0], bin_sh[DISP_BITS-1]};
        bin_nxt = bin_sh << 1;
        if (f != conv_f) pend_nxt = 1'b1;
        if (bit_cnt == '0) state_nxt = DONE;
        else               cnt_nxt   = bit_cnt - 1'b1;
      end
      DONE: begin
        for (int d = 0; d < DIGITS; d++) hex_nxt[7*d +: 7] = seg_encode(bcd[4*d +: 4]);
        shown_f_nxt = conv_f;
        pend_nxt    = 1'b0;
        if (pending || (f != conv_f)) begin
          conv_f_nxt = f;
          bin_nxt    = f;
          bcd_nxt    = '0;
          cnt_nxt    = CNT_W'(DISP_BITS - 1);
          state_nxt  = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Valid as soon as the published field matches the live one; drops the cycle the PC moves.
  assign disp_valid = (f == shown_f);

endmodule

// File: tb/tb_pc_step_display.sv
// Directed bench for pc_step_display with short debounce and run periods.
module tb_pc_step_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [20:0] H000 = {S0, S0, S0};
  localparam logic [20:0] H001 = {S0, S0, S1};
  localparam logic [20:0] H255 = {S2, S5, S5};
  localparam logic [20:0] H099 = {S0, S9, S9};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_key_n = 1'b1;
  logic        run_en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_value = '0;
  logic [31:0] pc;
  logic [20:0] hex_n;
  logic        disp_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_step_display #(.DEBOUNCE_CYC(8), .RUN_DIV(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_key_n (step_key_n),
    .run_en     (run_en),
    .load       (load),
    .load_value (load_value),
    .pc         (pc),
    .hex_n      (hex_n),
    .disp_valid (disp_valid)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_and_release(input int low_cyc);
    step_key_n = 1'b0;
    cycles(low_cyc);
    step_key_n = 1'b1;
    cycles(20);
  endtask

  task automatic pulse_load(input logic [31:0] val);
    load = 1'b1;
    load_value = val;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(3);
    vectors++;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'd0); end
    vectors++;
    if (hex_n !== H000) begin miscompares++; $display("FAIL reset_hex got %b want %b", hex_n, H000); end
    vectors++;
    if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL reset_valid got %b want 1", disp_valid); end
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_key_step;
    step_key_n = 1'b0;
    cycles(20);
    vectors++;
    if (pc !== 32'd4) begin miscompares++; $display("FAIL key_step_pc got %h want %h", pc, 32'd4); end
    step_key_n = 1'b1;
    cycles(10);
    vectors++;
    if (hex_n !== H001) begin miscompares++; $display("FAIL key_step_hex got %b want %b", hex_n, H001); end
    vectors++;
    if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL key_step_valid got %b want 1", disp_valid); end
    cycles(15);
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 5; i++) begin
      step_key_n = 1'b0;
      cycles(3);
      step_key_n = 1'b1;
      cycles(3);
    end
    cycles(12);
    vectors++;
    if (pc !== 32'd4) begin miscompares++; $display("FAIL bounce_nostep_pc got %h want %h", pc, 32'd4); end
    press_and_release(20);
    vectors++;
    if (pc !== 32'd8) begin miscompares++; $display("FAIL bounce_step_pc got %h want %h", pc, 32'd8); end
  endtask

  // Key low before edge 1; step_evt is high during the cycle after edge 10.
  task automatic test_load_coincide;
    step_key_n = 1'b0;
    cycles(10);
    pulse_load(32'h3FC);
    cycles(20);
    vectors++;
    if (pc !== 32'h3FC) begin miscompares++; $display("FAIL load_prio_pc got %h want %h", pc, 32'h3FC); end
    vectors++;
    if (hex_n !== H255) begin miscompares++; $display("FAIL load_prio_hex got %b want %b", hex_n, H255); end
    vectors++;
    if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL load_prio_valid got %b want 1", disp_valid); end
    step_key_n = 1'b1;
    cycles(20);
  endtask

  task automatic test_wrap;
    pulse_load(32'hFFFF_FFFC);
    vectors++;
    if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_load_pc got %h want %h", pc, 32'hFFFF_FFFC); end
    cycles(15);
    press_and_release(20);
    vectors++;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL wrap_pc got %h want %h", pc, 32'd0); end
    vectors++;
    if (hex_n !== H000) begin miscompares++; $display("FAIL wrap_hex got %b want %b", hex_n, H000); end
    vectors++;
    if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %b want 1", disp_valid); end
  endtask

  task automatic test_back_to_back;
    int waited;
    bit seen;
    pulse_load(32'd40);
    vectors++;
    if (disp_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_drop got %b want 0", disp_valid); end
    vectors++;
    if (hex_n !== H000) begin miscompares++; $display("FAIL b2b_hex_hold got %b want %b", hex_n, H000); end
    cycles(2);
    pulse_load(32'd396);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 60) begin
      cycles(1);
      waited++;
      if (disp_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL b2b_timeout got no valid after %0d cycles want valid", waited); end
    vectors++;
    if (hex_n !== H099) begin miscompares++; $display("FAIL b2b_hex got %b want %b", hex_n, H099); end
    cycles(5);
  endtask

  task automatic test_run;
    run_en = 1'b1;
    cycles(64);
    run_en = 1'b0;
`ifdef PC_AUTORUN_EN
    vectors++;
    if (pc !== 32'd412) begin miscompares++; $display("FAIL run_advance_pc got %h want %h", pc, 32'd412); end
    cycles(40);
    vectors++;
    if (pc !== 32'd412) begin miscompares++; $display("FAIL run_frozen_pc got %h want %h", pc, 32'd412); end
`else
    vectors++;
    if (pc !== 32'd396) begin miscompares++; $display("FAIL run_ignored_pc got %h want %h", pc, 32'd396); end
    cycles(40);
`endif
  endtask

  task automatic test_reset_mid_shift;
    pulse_load(32'd20);
    cycles(3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (hex_n !== H000) begin miscompares++; $display("FAIL midreset_hex got %b want %b", hex_n, H000); end
    vectors++;
    if (pc !== 32'd0) begin miscompares++; $display("FAIL midreset_pc got %h want %h", pc, 32'd0); end
    cycles(2);
    reset = 1'b0;
    cycles(20);
    vectors++;
    if (hex_n !== H000) begin miscompares++; $display("FAIL midreset_after_hex got %b want %b", hex_n, H000); end
    vectors++;
    if (disp_valid !== 1'b1) begin miscompares++; $display("FAIL midreset_after_valid got %b want 1", disp_valid); end
  endtask

  initial begin
    test_reset;
    test_key_step;
    test_bounce;
    test_load_coincide;
    test_wrap;
    test_back_to_back;
    test_run;
    test_reset_mid_shift;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
